// File: rtl/aes_key_expander.sv
// Purpose: sequences an external AES-128 round-key stage and stores all round keys.
// Latency: 1+NUM_ROUNDS*(KS_LATENCY+1) cycles from an accepted key_load to done; reads take 1 cycle.
// Backpressure: none; key_load is ignored unless the FSM is in IDLE, and reads are always served.
module aes_key_expander #(
    parameter int KS_LATENCY = 2,
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         done,
    output logic         ready,
    output logic         ks_en,
    output logic [3:0]   ks_round,
    output logic [127:0] ks_din,
    input  logic [127:0] ks_dout,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    // Counter must reach KS_LATENCY; keep at least 2 bits.
    localparam int CNT_W_RAW = $clog2(KS_LATENCY + 1);
    localparam int CNT_W     = (CNT_W_RAW < 2) ? 2 : CNT_W_RAW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_rk [0:NUM_ROUNDS];
    logic [127:0]       r_cur;
    logic [3:0]         r_round;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic [127:0]       r_rk_data;

    logic               w_accept;
    logic               w_step_done;
    logic               w_last_round;

    // Stage output is captured on the last cycle the inputs have been held.
    assign w_accept     = (r_state == IDLE) && key_load;
    assign w_step_done  = (r_state == RUN) && (r_cnt == CNT_W'(KS_LATENCY));
    assign w_last_round = (r_round == 4'(NUM_ROUNDS));

    assign ready   = r_ready;
    assign rk_data = r_rk_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stage-drive decode; stage inputs are zero outside RUN so it never sees stale data.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        ks_en       = 1'b0;
        ks_round    = 4'd0;
        ks_din      = '0;
        case (r_state)
            IDLE: begin
                if (key_load) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                ks_en    = 1'b1;
                ks_round = r_round;
                ks_din   = r_cur;
                if (w_step_done && w_last_round) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Round sequencing, key store writes and the ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur   <= '0;
            r_round <= 4'd0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_rk[i] <= '0;
            end
        end else if (w_accept) begin
            r_rk[0] <= key_in;
            r_cur   <= key_in;
            r_round <= 4'd1;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_step_done) begin
                r_rk[r_round] <= ks_dout;
                r_cur         <= ks_dout;
                r_cnt         <= '0;
                if (w_last_round) begin
                    r_ready <= 1'b1;
                end else begin
                    r_round <= r_round + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Registered read port; a same-edge write is seen on the following read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk_data <= '0;
        end else if (rk_addr <= 4'(NUM_ROUNDS)) begin
            r_rk_data <= r_rk[rk_addr];
        end else begin
            r_rk_data <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Purpose: randomized self-checking bench for aes_key_expander with a behavioural AES key schedule.
// Latency: models a 2-cycle round stage (input register, then registered key step).
// Backpressure: none; stimulus drives key_load/rk_addr directly.
module tb_aes_key_expander;

    localparam int LAT = 2;
    localparam int NR  = 10;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         done;
    logic         ready;
    logic         ks_en;
    logic [3:0]   ks_round;
    logic [127:0] ks_din;
    logic [127:0] ks_dout;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox [256];
    logic [127:0] exp_rk [NR+1];

    aes_key_expander #(.KS_LATENCY(LAT), .NUM_ROUNDS(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .done     (done),
        .ready    (ready),
        .ks_en    (ks_en),
        .ks_round (ks_round),
        .ks_din   (ks_din),
        .ks_dout  (ks_dout),
        .rk_addr  (rk_addr),
        .rk_data  (rk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from the multiplicative inverse followed by the affine transform.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] b;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < int'(rnd); i++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    // One AES-128 key schedule step: previous round key -> next round key.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w [4];
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] n [4];
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rot = {w[3][23:0], w[3][31:24]};
        t = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]};
        t = t ^ {rcon(rnd), 24'h000000};
        n[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i-1];
        return {n[0], n[1], n[2], n[3]};
    endfunction

    task automatic expand(input logic [127:0] key);
        exp_rk[0] = key;
        for (int r = 1; r <= NR; r++) exp_rk[r] = key_step(exp_rk[r-1], 4'(r));
    endtask

    // Round-stage model: registers din/round, then a registered key step.
    logic [127:0] st_s1   = '0;
    logic [3:0]   st_r1   = '0;
    logic [127:0] st_dout = '0;
    always @(posedge clk) begin
        if (ks_en) begin
            st_s1   <= ks_din;
            st_r1   <= ks_round;
            st_dout <= key_step(st_s1, st_r1);
        end
    end
    assign ks_dout = st_dout;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one expansion starting in local cycle 0 and checks the sequencing every cycle.
    // intrude: extra key_load in cycles 10 and 31; abort_at >= 0: rst during that cycle.
    task automatic run_expand(input logic [127:0] key, input bit intrude, input int abort_at);
        int  r;
        bit  in_run;
        expand(key);
        for (int cyc = 0; cyc <= 31; cyc++) begin
            @(posedge clk);
            #1;
            key_load = (cyc == 0) || (intrude && (cyc == 10 || cyc == 31));
            key_in   = (cyc == 0) ? key : ~key;
            rk_addr  = 4'($urandom_range(0, 15));
            rst      = (cyc == abort_at);
            @(negedge clk);
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_ready", ready, 0);
                chk("abort_ks_en", ks_en, 0);
                chk("abort_done", done, 0);
                chk("abort_ks_round", ks_round, 0);
                chk("abort_ks_din", ks_din, 0);
                chk("abort_rk_data", rk_data, 0);
                return;
            end
            in_run = (cyc >= 1 && cyc <= 30);
            r      = in_run ? (cyc - 1) / (LAT + 1) + 1 : 0;
            chk("busy", busy, in_run);
            chk("ks_en", ks_en, in_run);
            chk("done", done, cyc == 31);
            if (cyc >= 1) chk("ready", ready, cyc == 31);
            chk("ks_round", ks_round, r);
            if (in_run) chk("ks_din", ks_din, exp_rk[r-1]);
        end
        key_load = 1'b0;
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        key_load = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_ready", ready, 1);
        chk("idle_ks_en", ks_en, 0);
    endtask

    task automatic read_one(input logic [3:0] a, input logic [127:0] e, input string tag);
        @(posedge clk);
        #1;
        rk_addr = a;
        @(posedge clk);
        #1;
        chk(tag, rk_data, e);
    endtask

    // Streams addresses 0..15, checking each result one cycle after its address.
    task automatic readback(input bit all_zero);
        logic [127:0] e;
        for (int a = 0; a <= 16; a++) begin
            @(posedge clk);
            #1;
            key_load = 1'b0;
            if (a < 16) rk_addr = 4'(a);
            @(negedge clk);
            if (a > 0) begin
                e = (all_zero || a - 1 > NR) ? 128'h0 : exp_rk[a-1];
                chk($sformatf("rk_read%0d", a - 1), rk_data, e);
            end
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) sbox[i] = calc_sbox(8'(i));
        rst      = 1'b1;
        key_load = 1'b0;
        key_in   = '0;
        rk_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 0);
        chk("rst_ks_en", ks_en, 0);
        chk("rst_ks_round", ks_round, 0);
        chk("rst_ks_din", ks_din, 0);
        chk("rst_rk_data", rk_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // FIPS-197 key with ignored key_loads during RUN and FIN.
        run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, -1);
        idle_check();
        read_one(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_rk0");
        read_one(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
        read_one(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
        readback(1'b0);

        // All-zero key.
        run_expand(128'h0, 1'b0, -1);
        read_one(4'd1,  128'h62636363626363636263636362636363, "zero_rk1");
        read_one(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        // Reset in the middle of an expansion, then a clean restart.
        run_expand(rand_key(), 1'b0, 15);
        rst = 1'b0;
        readback(1'b1);
        run_expand(rand_key(), 1'b0, -1);
        readback(1'b0);

        // Back-to-back: second key_load lands in the first IDLE cycle with ready=1.
        run_expand(rand_key(), 1'b0, -1);
        run_expand(rand_key(), 1'b0, -1);
        readback(1'b0);

        for (int k = 0; k < 3; k++) begin
            run_expand(rand_key(), 1'b0, -1);
            readback(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
